// File: rtl/warp_pkg.sv
// Shared types for the SIMT divergence controller: stack entry layout and FSM states.
package warp_pkg;

    localparam int unsigned WARP_PC_WIDTH  = 32;
    localparam int unsigned WARP_NUM_LANES = 8;

    typedef struct packed {
        logic [WARP_PC_WIDTH-1:0]  pc;
        logic [WARP_NUM_LANES-1:0] mask;
        logic [WARP_PC_WIDTH-1:0]  rpc;
    } simt_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        PUSH_RC,
        PUSH_NT,
        POP
    } simt_state_e;

endpackage

// File: rtl/warp_simt_ctrl_if.sv
// Branch-resolution / fetch-side signal bundle of the SIMT controller.
interface warp_simt_ctrl_if #(
    parameter int unsigned NUM_LANES   = 8,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned PC_WIDTH    = 32
);
    localparam int unsigned DW = $clog2(STACK_DEPTH) + 1;

    logic                 branch_valid;
    logic                 branch_ready;
    logic [NUM_LANES-1:0] branch_pred;
    logic [PC_WIDTH-1:0]  branch_target;
    logic [PC_WIDTH-1:0]  branch_fallthru;
    logic [PC_WIDTH-1:0]  branch_reconv;
    logic                 pc_valid;
    logic [PC_WIDTH-1:0]  pc_in;
    logic                 mask_update;
    logic [NUM_LANES-1:0] mask_out;
    logic [NUM_LANES-1:0] active_mask;
    logic                 redirect_valid;
    logic [PC_WIDTH-1:0]  redirect_pc;
    logic [DW-1:0]        depth;
    logic                 overflow_err;

    modport master (
        output branch_valid, branch_pred, branch_target, branch_fallthru, branch_reconv,
        output pc_valid, pc_in,
        input  branch_ready, mask_update, mask_out, active_mask, redirect_valid, redirect_pc,
        input  depth, overflow_err
    );

    modport slave (
        input  branch_valid, branch_pred, branch_target, branch_fallthru, branch_reconv,
        input  pc_valid, pc_in,
        output branch_ready, mask_update, mask_out, active_mask, redirect_valid, redirect_pc,
        output depth, overflow_err
    );

endinterface

// File: rtl/simt_stack.sv
// LIFO of reconvergence contexts; only the occupancy pointer is reset, storage is not.
module simt_stack
    import warp_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  simt_entry_t                      push_data,
    output simt_entry_t                      tos,
    output logic [$clog2(STACK_DEPTH):0]     depth,
    output logic                             full_minus1
);
    localparam int unsigned AW = $clog2(STACK_DEPTH);
    localparam logic [AW:0] ONE       = (AW + 1)'(1);
    localparam logic [AW:0] DEPTH_MAX = (AW + 1)'(STACK_DEPTH);
    localparam logic [AW:0] ROOM_TWO  = (AW + 1)'(STACK_DEPTH - 2);

    simt_entry_t       mem [STACK_DEPTH];
    logic [AW:0]       depth_q;
    logic [AW-1:0]     top_idx;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        do_push     = push && !pop && (depth_q < DEPTH_MAX);
        do_pop      = pop && !push && (depth_q != '0);
        top_idx     = depth_q[AW-1:0] - AW'(1);
        tos         = mem[top_idx];
        full_minus1 = depth_q > ROOM_TWO;
        depth       = depth_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
        end else if (do_push) begin
            depth_q <= depth_q + ONE;
        end else if (do_pop) begin
            depth_q <= depth_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[depth_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/warp_simt_ctrl.sv
// SIMT divergence/reconvergence controller: narrows the lane mask on divergent branches
// and restores it from the stack when the reconvergence PC is issued.
module warp_simt_ctrl
    import warp_pkg::*;
#(
    parameter int unsigned NUM_LANES   = WARP_NUM_LANES,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned PC_WIDTH    = WARP_PC_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    warp_simt_ctrl_if.slave bus
);
    localparam int unsigned DW = $clog2(STACK_DEPTH) + 1;

    simt_state_e          state_q;
    logic [NUM_LANES-1:0] active_q;
    logic [NUM_LANES-1:0] mask_out_q;
    logic [NUM_LANES-1:0] op_taken_q;
    logic [NUM_LANES-1:0] op_nt_q;
    logic [PC_WIDTH-1:0]  cur_rpc_q;
    logic [PC_WIDTH-1:0]  redirect_pc_q;
    logic [PC_WIDTH-1:0]  op_target_q;
    logic [PC_WIDTH-1:0]  op_fallthru_q;
    logic [PC_WIDTH-1:0]  op_reconv_q;
    logic                 mask_update_q;
    logic                 redirect_valid_q;
    logic                 overflow_q;

    logic [NUM_LANES-1:0] taken;
    logic [NUM_LANES-1:0] nt;
    logic                 reconv_hit;
    logic                 push;
    logic                 pop;
    logic                 full_minus1;
    logic [DW-1:0]        depth;
    simt_entry_t          push_data;
    simt_entry_t          tos;

    always_comb begin
        taken      = bus.branch_pred & active_q;
        nt         = ~bus.branch_pred & active_q;
        reconv_hit = (state_q == IDLE) && bus.pc_valid && (depth != '0) &&
                     (bus.pc_in == cur_rpc_q);
        push       = (state_q == PUSH_RC) || (state_q == PUSH_NT);
        pop        = (state_q == POP);
        // PUSH_RC saves the enclosing context; PUSH_NT saves the deferred not-taken path.
        if (state_q == PUSH_NT) begin
            push_data = '{pc: op_fallthru_q, mask: op_nt_q, rpc: op_reconv_q};
        end else begin
            push_data = '{pc: op_reconv_q, mask: active_q, rpc: cur_rpc_q};
        end
    end

    simt_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .push_data   (push_data),
        .tos         (tos),
        .depth       (depth),
        .full_minus1 (full_minus1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            active_q         <= '1;
            mask_out_q       <= '1;
            cur_rpc_q        <= '0;
            redirect_pc_q    <= '0;
            mask_update_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            overflow_q       <= 1'b0;
            op_taken_q       <= '0;
            op_nt_q          <= '0;
            op_target_q      <= '0;
            op_fallthru_q    <= '0;
            op_reconv_q      <= '0;
        end else begin
            mask_update_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (reconv_hit) begin
                        state_q <= POP;
                    end else if (bus.branch_valid) begin
                        if (taken == '0) begin
                            // all active lanes fall through: nothing to do
                        end else if (nt == '0) begin
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= bus.branch_target;
                        end else if (full_minus1) begin
                            overflow_q <= 1'b1;
                        end else begin
                            op_taken_q    <= taken;
                            op_nt_q       <= nt;
                            op_target_q   <= bus.branch_target;
                            op_fallthru_q <= bus.branch_fallthru;
                            op_reconv_q   <= bus.branch_reconv;
                            state_q       <= PUSH_RC;
                        end
                    end
                end
                PUSH_RC: begin
                    state_q <= PUSH_NT;
                end
                PUSH_NT: begin
                    active_q         <= op_taken_q;
                    mask_out_q       <= op_taken_q;
                    cur_rpc_q        <= op_reconv_q;
                    mask_update_q    <= 1'b1;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= op_target_q;
                    state_q          <= IDLE;
                end
                POP: begin
                    active_q         <= tos.mask;
                    mask_out_q       <= tos.mask;
                    cur_rpc_q        <= tos.rpc;
                    mask_update_q    <= 1'b1;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= tos.pc;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.branch_ready   = (state_q == IDLE) && !reconv_hit;
    assign bus.mask_update    = mask_update_q;
    assign bus.mask_out       = mask_out_q;
    assign bus.active_mask    = active_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.depth          = depth;
    assign bus.overflow_err   = overflow_q;

endmodule

// File: tb/tb_warp_simt_ctrl.sv
// Directed bench for warp_simt_ctrl; pulse events are checked against a scoreboard queue.
module tb_warp_simt_ctrl;

    typedef struct {
        int          due;
        logic        mu;
        logic [7:0]  mask;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    warp_simt_ctrl_if #(.NUM_LANES(8), .STACK_DEPTH(8), .PC_WIDTH(32)) bus ();

    warp_simt_ctrl #(
        .NUM_LANES   (8),
        .STACK_DEPTH (8),
        .PC_WIDTH    (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int due, input logic mu, input logic [7:0] m,
                             input logic [31:0] pc);
        exp_t e;
        e.due  = due;
        e.mu   = mu;
        e.mask = m;
        e.pc   = pc;
        sb.push_back(e);
    endtask

    task automatic branch(input logic [7:0] pred, input logic [31:0] tgt,
                          input logic [31:0] fall, input logic [31:0] rcv);
        bus.branch_pred     = pred;
        bus.branch_target   = tgt;
        bus.branch_fallthru = fall;
        bus.branch_reconv   = rcv;
        bus.branch_valid    = 1'b1;
        tick(1);
        bus.branch_valid    = 1'b0;
    endtask

    task automatic issue_pc(input logic [31:0] pc);
        bus.pc_in    = pc;
        bus.pc_valid = 1'b1;
        tick(1);
        bus.pc_valid = 1'b0;
    endtask

    // Every mask_update/redirect_valid cycle must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && (bus.mask_update || bus.redirect_valid)) begin
            check("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.due));
                check("pulse_redirect_valid", 32'(bus.redirect_valid), 32'd1);
                check("pulse_mask_update", 32'(bus.mask_update), 32'(e.mu));
                check("pulse_mask_out", 32'(bus.mask_out), 32'(e.mask));
                check("pulse_redirect_pc", bus.redirect_pc, e.pc);
            end
        end
    end

    initial begin
        bit accepted;
        n_checks = 0;
        n_errors = 0;
        rst                 = 1'b1;
        bus.branch_valid    = 1'b0;
        bus.branch_pred     = '0;
        bus.branch_target   = '0;
        bus.branch_fallthru = '0;
        bus.branch_reconv   = '0;
        bus.pc_valid        = 1'b0;
        bus.pc_in           = '0;
        tick(2);
        check("rst_active_mask", 32'(bus.active_mask), 32'hFF);
        check("rst_mask_out", 32'(bus.mask_out), 32'hFF);
        check("rst_depth", 32'(bus.depth), 32'd0);
        check("rst_overflow", 32'(bus.overflow_err), 32'd0);
        check("rst_redirect_pc", bus.redirect_pc, 32'd0);
        check("rst_mask_update", 32'(bus.mask_update), 32'd0);
        rst = 1'b0;
        tick(5);
        check("idle_active_mask", 32'(bus.active_mask), 32'hFF);
        check("idle_depth", 32'(bus.depth), 32'd0);
        check("idle_ready", 32'(bus.branch_ready), 32'd1);

        // basic divergence and two pops
        expect_ev(cyc + 3, 1'b1, 8'h0F, 32'h100);
        branch(8'h0F, 32'h100, 32'h40, 32'h80);
        tick(3);
        check("div_depth", 32'(bus.depth), 32'd2);
        check("div_active", 32'(bus.active_mask), 32'h0F);
        expect_ev(cyc + 2, 1'b1, 8'hF0, 32'h40);
        issue_pc(32'h80);
        tick(3);
        check("pop1_depth", 32'(bus.depth), 32'd1);
        check("pop1_active", 32'(bus.active_mask), 32'hF0);
        expect_ev(cyc + 2, 1'b1, 8'hFF, 32'h80);
        issue_pc(32'h80);
        tick(3);
        check("pop2_depth", 32'(bus.depth), 32'd0);
        check("pop2_active", 32'(bus.active_mask), 32'hFF);

        // pc_in matching cur_rpc with an empty stack must not pop
        issue_pc(32'h0);
        tick(2);
        check("empty_no_pop_depth", 32'(bus.depth), 32'd0);

        // uniform branches
        expect_ev(cyc + 1, 1'b0, 8'hFF, 32'h200);
        branch(8'hFF, 32'h200, 32'h240, 32'h280);
        branch(8'h00, 32'h300, 32'h340, 32'h380);
        tick(3);
        check("uniform_depth", 32'(bus.depth), 32'd0);
        check("uniform_active", 32'(bus.active_mask), 32'hFF);
        check("uniform_drained", 32'(sb.size()), 32'd0);

        // nested divergence up to a full stack, then overflow
        for (int i = 0; i < 4; i++) begin
            logic [7:0] p;
            p = 8'hFF >> (i + 1);
            expect_ev(cyc + 3, 1'b1, p, 32'h1000 + 32'(i * 16));
            branch(p, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), 32'h3000 + 32'(i * 16));
            tick(3);
        end
        check("nest_depth", 32'(bus.depth), 32'd8);
        check("nest_active", 32'(bus.active_mask), 32'h0F);
        branch(8'h07, 32'h5000, 32'h5040, 32'h5080);
        tick(4);
        check("ovf_err", 32'(bus.overflow_err), 32'd1);
        check("ovf_depth", 32'(bus.depth), 32'd8);
        check("ovf_active", 32'(bus.active_mask), 32'h0F);
        expect_ev(cyc + 2, 1'b1, 8'h10, 32'h2030);
        issue_pc(32'h3030);
        tick(3);
        check("npop1_depth", 32'(bus.depth), 32'd7);
        expect_ev(cyc + 2, 1'b1, 8'h1F, 32'h3030);
        issue_pc(32'h3030);
        tick(3);
        check("npop2_depth", 32'(bus.depth), 32'd6);
        check("npop2_active", 32'(bus.active_mask), 32'h1F);
        check("ovf_sticky", 32'(bus.overflow_err), 32'd1);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst2_overflow", 32'(bus.overflow_err), 32'd0);
        check("rst2_depth", 32'(bus.depth), 32'd0);

        // branch arriving together with a reconvergence hit
        expect_ev(cyc + 3, 1'b1, 8'h0F, 32'h100);
        branch(8'h0F, 32'h100, 32'h40, 32'h80);
        tick(3);
        bus.pc_in           = 32'h80;
        bus.pc_valid        = 1'b1;
        bus.branch_pred     = 8'h30;
        bus.branch_target   = 32'h300;
        bus.branch_fallthru = 32'h340;
        bus.branch_reconv   = 32'h380;
        bus.branch_valid    = 1'b1;
        #1;
        check("collide_ready", 32'(bus.branch_ready), 32'd0);
        expect_ev(cyc + 2, 1'b1, 8'hF0, 32'h40);
        tick(1);
        bus.pc_valid = 1'b0;
        accepted = 1'b0;
        for (int i = 0; i < 8 && !accepted; i++) begin
            if (bus.branch_ready) begin
                expect_ev(cyc + 3, 1'b1, 8'h30, 32'h300);
                tick(1);
                accepted = 1'b1;
            end else begin
                tick(1);
            end
        end
        bus.branch_valid = 1'b0;
        check("collide_accepted", 32'(accepted), 32'd1);
        tick(4);
        check("collide_depth", 32'(bus.depth), 32'd3);
        check("collide_active", 32'(bus.active_mask), 32'h30);

        // reset during PUSH_NT discards the partial push and emits no pulses
        branch(8'h10, 32'h400, 32'h440, 32'h480);
        tick(1);
        rst = 1'b1;
        #1;
        check("midrst_active", 32'(bus.active_mask), 32'hFF);
        check("midrst_mask_out", 32'(bus.mask_out), 32'hFF);
        check("midrst_depth", 32'(bus.depth), 32'd0);
        tick(1);
        check("midrst_mask_update", 32'(bus.mask_update), 32'd0);
        check("midrst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("midrst_redirect_pc", bus.redirect_pc, 32'd0);
        rst = 1'b0;
        tick(4);
        check("midrst_after_depth", 32'(bus.depth), 32'd0);
        check("midrst_after_ready", 32'(bus.branch_ready), 32'd1);
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/warp_simt_ctrl.md
Name: warp_simt_ctrl

Overview:
- Divergence/reconvergence controller that sequences the warp lane-enable mask.
- On a divergent branch it pushes reconvergence and not-taken contexts onto a SIMT stack, narrows the active mask to the taken lanes and redirects fetch.
- On reaching the reconvergence PC it pops the stack, restores the mask and redirects.
- Drives warp_mask through mask_update/mask_out; sits between branch resolution and fetch.

Parameters:
- NUM_LANES, 8, lanes per warp.
- STACK_DEPTH, 8, SIMT stack entries (power of two, >=2).
- PC_WIDTH, 32, program counter width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- branch_valid  input  1  resolved branch presented
- branch_ready  output  1  controller accepts branch this cycle
- branch_pred  input  NUM_LANES  per-lane taken predicate
- branch_target  input  PC_WIDTH  taken PC
- branch_fallthru  input  PC_WIDTH  not-taken PC
- branch_reconv  input  PC_WIDTH  immediate post-dominator PC
- pc_valid  input  1  pc_in is the PC being issued
- pc_in  input  PC_WIDTH  issued PC
- mask_update  output  1  one-cycle pulse, load mask_out into warp_mask
- mask_out  output  NUM_LANES  new lane mask
- active_mask  output  NUM_LANES  current active mask (registered)
- redirect_valid  output  1  one-cycle fetch redirect pulse
- redirect_pc  output  PC_WIDTH  redirect target
- depth  output  $clog2(STACK_DEPTH)+1  stack occupancy
- overflow_err  output  1  sticky, divergent branch dropped for lack of space

Behaviour:
- Reset values:
  - active_mask = mask_out = all ones; cur_rpc = 0; depth = 0.
  - mask_update = redirect_valid = overflow_err = 0; redirect_pc = 0.
  - FSM state = IDLE.
- Stack entry: {pc, mask, rpc}. cur_rpc is a register holding the reconvergence PC of the executing path.
- reconv_hit = IDLE && pc_valid && depth!=0 && pc_in==cur_rpc.
- branch_ready = IDLE && !reconv_hit. Reconvergence has priority over a simultaneous branch.
- On branch accept, with taken = branch_pred & active_mask and nt = ~branch_pred & active_mask:
  - Uniform not-taken (taken==0): no state change, no pulses.
  - Uniform taken (nt==0): next cycle redirect_valid=1 with redirect_pc=branch_target; mask unchanged; stays IDLE.
  - Divergent, depth <= STACK_DEPTH-2: latch operands, go to PUSH_RC.
  - Divergent, depth > STACK_DEPTH-2: overflow_err<=1 (sticky until rst); branch dropped; no pulses.
- PUSH_RC (1 cycle): push {branch_reconv, active_mask, cur_rpc}; go to PUSH_NT.
- PUSH_NT (1 cycle): push {branch_fallthru, nt, branch_reconv}.
  - Same edge: active_mask<=taken, cur_rpc<=branch_reconv, mask_out<=taken.
  - Next cycle: mask_update=1, redirect_valid=1, redirect_pc=branch_target; state back to IDLE.
  - Branch latency: accept at cycle N, pulses at N+2; depth +2.
- reconv_hit: go to POP.
- POP (1 cycle): read TOS; active_mask<=TOS.mask, mask_out<=TOS.mask, cur_rpc<=TOS.rpc; depth -1.
  - Next cycle: mask_update=1, redirect_valid=1, redirect_pc=TOS.pc, even when TOS.pc==pc_in.
  - Pop latency: hit at cycle N, pulses at N+2.
- branch_ready=0 in PUSH_RC, PUSH_NT and POP; pc_valid is ignored outside IDLE.
- mask_update and redirect_valid are never high for more than one cycle per event.
- Stack never underflows (depth!=0 guard) and never overflows (pre-check).
- rst asserted mid-sequence: immediate return to reset values; partial pushes discarded; no pulses.

Decomposition:
- warp_pkg:
  - simt_entry_t struct {pc, mask, rpc}, parameterised widths via package constants.
  - simt_state_e enum {IDLE, PUSH_RC, PUSH_NT, POP}.
  - WARP_PC_WIDTH constant.
- Sub-module simt_stack:
  - STACK_DEPTH-entry LIFO of simt_entry_t with push, pop, tos, depth, full_minus1.
  - Asynchronous active-high reset of the depth pointer only.

Test Plan:
- Reset, then idle 5 cycles -> active_mask=8'hFF, depth=0, branch_ready=1, no pulses.
- Branch pred=8'h0F, target=0x100, fallthru=0x40, reconv=0x80 -> 2 cycles later mask_out=8'h0F, mask_update and redirect to 0x100 pulse once, depth=2.
- Then pc_in=0x80 -> pop: mask 8'hF0, redirect 0x40, depth=1. Then pc_in=0x80 again -> mask 8'hFF, redirect 0x80, depth=0.
- Uniform cases from 8'hFF: pred=8'hFF -> redirect to target only, no mask_update. pred=8'h00 -> no pulses.
- Nested divergence: 4 successive divergent branches with STACK_DEPTH=8 -> depth=8. A 5th branch -> overflow_err=1, depth stays 8, no pulses.
- Branch valid in the same cycle as reconv_hit -> branch_ready=0, pop completes, branch accepted in a following IDLE cycle. rst pulsed during PUSH_NT -> all outputs at reset values next cycle.
